// File: rtl/ics_pkg.sv
// ics_pkg: shared definitions for the combine/packing stage.
//   - ics_state_e : job state (IDLE / RUN / DRAIN)
//   - ICS_*       : default geometry used by ics_combine_pack
//   - ics_num_w   : width of the valid-row count carried with each beat
//   - ics_idx_w   : width of a part index
package ics_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ics_state_e;

    localparam int ICS_NUM_PART = 3;
    localparam int ICS_ROW_W    = 10;
    localparam int ICS_OUT_ROWS = 12;
    localparam int ICS_LEN_W    = 14;

    // Count must reach OUT_ROWS itself, hence the +1.
    function automatic int ics_num_w(input int outRows);
        return $clog2(outRows + 1);
    endfunction

    function automatic int ics_idx_w(input int numPart);
        return (numPart > 1) ? $clog2(numPart) : 1;
    endfunction

endpackage

// File: rtl/ics_rr_sel.sv
// ics_rr_sel: combinational round-robin successor.
//   cur     in  index of the current part
//   mask    in  one bit per part, 1 = part still has rows
//   nextIdx out first part after cur (cyclic, increasing) with its mask bit set;
//               cur itself is considered last, so a lone survivor is kept
//   any     out 1 when any mask bit is set (nextIdx is cur otherwise)
module ics_rr_sel
    import ics_pkg::*;
#(
    parameter int NUM_PART = ICS_NUM_PART,
    parameter int PW       = ics_idx_w(NUM_PART)
)(
    input  logic [PW-1:0]       cur,
    input  logic [NUM_PART-1:0] mask,
    output logic [PW-1:0]       nextIdx,
    output logic                any
);

    int idx;

    always_comb begin
        nextIdx = cur;
        any     = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NUM_PART; i++) begin
            idx = int'(cur) + i;
            if (idx >= NUM_PART) begin
                idx = idx - NUM_PART;
            end
            if (!any && mask[idx]) begin
                any     = 1'b1;
                nextIdx = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/ics_combine_pack.sv
// ics_combine_pack: merges row streams from NUM_PART parts in round-robin
// units of q_size rows and packs them into OUT_ROWS-row output beats.
//   clk, rst              clock, synchronous active-high reset
//   start                 job start, samples q_size / part_en / part_rows
//   in_vld/in_data/in_rdy per-part row handshake (one in_rdy high at most)
//   out_vld/out_sof/out_eof/out_num/out_data, out_rdy  beat handshake
//   busy                  job in progress
//   done                  one-cycle pulse once the job's last beat is taken
// Build option: ICS_PACK_BP_EN - when defined out_rdy is honoured; when
// undefined every beat is taken the cycle it is presented.
module ics_combine_pack
    import ics_pkg::*;
#(
    parameter  int NUM_PART = ICS_NUM_PART,
    parameter  int ROW_W    = ICS_ROW_W,
    parameter  int OUT_ROWS = ICS_OUT_ROWS,
    parameter  int LEN_W    = ICS_LEN_W,
    localparam int NUM_W    = ics_num_w(OUT_ROWS),
    localparam int PW       = ics_idx_w(NUM_PART)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                q_size,
    input  logic [NUM_PART-1:0]       part_en,
    input  logic [NUM_PART*LEN_W-1:0] part_rows,
    input  logic [NUM_PART-1:0]       in_vld,
    input  logic [NUM_PART*ROW_W-1:0] in_data,
    output logic [NUM_PART-1:0]       in_rdy,
    output logic                      out_vld,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic [NUM_W-1:0]          out_num,
    output logic [OUT_ROWS*ROW_W-1:0] out_data,
    input  logic                      out_rdy,
    output logic                      busy,
    output logic                      done
);

    ics_state_e                stateReg;
    logic [PW-1:0]             curReg;
    logic [3:0]                qReg;
    logic [3:0]                unitReg;
    logic [LEN_W-1:0]          remReg [NUM_PART];
    logic [OUT_ROWS*ROW_W-1:0] accReg;
    logic [NUM_W-1:0]          kReg;
    logic                      accClosedReg;   // full/final beat waiting for the output register
    logic                      accLastReg;     // that waiting beat ends the job
    logic                      sofPendReg;     // next beat handed out is the job's first
    logic                      outVldReg;
    logic                      outSofReg;
    logic                      outEofReg;
    logic [NUM_W-1:0]          outNumReg;
    logic [OUT_ROWS*ROW_W-1:0] outDataReg;
    logic                      doneReg;

    logic                      rdyEff;
    logic [NUM_PART-1:0]       startRemNz;
    logic [NUM_PART-1:0]       runRemNz;
    logic [NUM_PART-1:0]       selMask;
    logic [PW-1:0]             selCur;
    logic [PW-1:0]             selIdx;
    logic                      selAny;
    logic                      curVld;
    logic [ROW_W-1:0]          curData;
    logic                      curNzNext;
    logic                      rowAcc;
    logic                      jobLast;
    logic                      unitDone;
    logic                      closeNow;
    logic                      outFree;
    logic                      transfer;
    logic [NUM_W-1:0]          kInc;
    logic [3:0]                unitInc;
    logic [OUT_ROWS*ROW_W-1:0] accFlat;

`ifdef ICS_PACK_BP_EN
    assign rdyEff = out_rdy;
`else
    // out_rdy is read but has no effect: the output register always drains.
    assign rdyEff = 1'b1 | out_rdy;
`endif

    // Remaining-row masks: at start (disabled parts count as empty) and
    // after the row being accepted this cycle has been taken.
    generate
        for (genvar gi = 0; gi < NUM_PART; gi++) begin : g_part
            assign startRemNz[gi] = part_en[gi] && (part_rows[gi*LEN_W +: LEN_W] != '0);
            assign runRemNz[gi]   = (rowAcc && (curReg == PW'(gi))) ?
                                    (remReg[gi] != LEN_W'(1)) : (remReg[gi] != '0);
            assign in_rdy[gi]     = (stateReg == RUN) && !accClosedReg && (curReg == PW'(gi));
        end
    endgenerate

    always_comb begin
        curVld    = 1'b0;
        curData   = '0;
        curNzNext = 1'b0;
        for (int p = 0; p < NUM_PART; p++) begin
            if (curReg == PW'(p)) begin
                curVld    = in_vld[p];
                curData   = in_data[p*ROW_W +: ROW_W];
                curNzNext = runRemNz[p];
            end
        end
    end

    // In IDLE the search starts from the last index so it wraps to the
    // lowest-index part with rows.
    assign selCur  = (stateReg == IDLE) ? PW'(NUM_PART - 1) : curReg;
    assign selMask = (stateReg == IDLE) ? startRemNz : runRemNz;

    ics_rr_sel #(
        .NUM_PART (NUM_PART),
        .PW       (PW)
    ) u_rr_sel (
        .cur     (selCur),
        .mask    (selMask),
        .nextIdx (selIdx),
        .any     (selAny)
    );

    assign rowAcc   = (stateReg == RUN) && !accClosedReg && curVld;
    assign kInc     = kReg + 1'b1;
    assign unitInc  = unitReg + 4'd1;
    assign jobLast  = rowAcc && !selAny;
    assign unitDone = rowAcc && ((unitInc == qReg) || !curNzNext);
    assign closeNow = rowAcc && ((kInc == NUM_W'(OUT_ROWS)) || jobLast);
    assign outFree  = !outVldReg || rdyEff;
    // A beat closing this cycle goes straight to the output register when it
    // is free, so the full beat appears the cycle after its last row.
    assign transfer = (closeNow || accClosedReg) && outFree;

    // Accumulator with this cycle's row inserted; slot 0 sits in the MSBs.
    generate
        for (genvar gi = 0; gi < OUT_ROWS; gi++) begin : g_slot
            assign accFlat[(OUT_ROWS-1-gi)*ROW_W +: ROW_W] =
                (rowAcc && (kReg == NUM_W'(gi))) ? curData
                                                 : accReg[(OUT_ROWS-1-gi)*ROW_W +: ROW_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= IDLE;
            curReg       <= '0;
            qReg         <= 4'd1;
            unitReg      <= '0;
            for (int p = 0; p < NUM_PART; p++) begin
                remReg[p] <= '0;
            end
            accReg       <= '0;
            kReg         <= '0;
            accClosedReg <= 1'b0;
            accLastReg   <= 1'b0;
            sofPendReg   <= 1'b0;
            outVldReg    <= 1'b0;
            outSofReg    <= 1'b0;
            outEofReg    <= 1'b0;
            outNumReg    <= '0;
            outDataReg   <= '0;
            doneReg      <= 1'b0;
        end else begin
            doneReg <= 1'b0;

            if (transfer) begin
                outVldReg  <= 1'b1;
                outDataReg <= accFlat;
                outNumReg  <= closeNow ? kInc : kReg;
                outSofReg  <= sofPendReg;
                outEofReg  <= closeNow ? jobLast : accLastReg;
                sofPendReg <= 1'b0;
            end else if (outVldReg && rdyEff) begin
                outVldReg <= 1'b0;
                outSofReg <= 1'b0;
                outEofReg <= 1'b0;
            end

            if (transfer) begin
                accReg       <= '0;
                kReg         <= '0;
                accClosedReg <= 1'b0;
                accLastReg   <= 1'b0;
            end else if (rowAcc) begin
                accReg <= accFlat;
                kReg   <= kInc;
                if (closeNow) begin
                    accClosedReg <= 1'b1;
                    accLastReg   <= jobLast;
                end
            end

            case (stateReg)
                IDLE: begin
                    if (start) begin
                        qReg    <= (q_size == 4'd0) ? 4'd1 : q_size;
                        unitReg <= '0;
                        for (int p = 0; p < NUM_PART; p++) begin
                            remReg[p] <= part_en[p] ? part_rows[p*LEN_W +: LEN_W] : '0;
                        end
                        if (selAny) begin
                            stateReg   <= RUN;
                            curReg     <= selIdx;
                            sofPendReg <= 1'b1;
                        end else begin
                            doneReg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rowAcc) begin
                        for (int p = 0; p < NUM_PART; p++) begin
                            if (curReg == PW'(p)) begin
                                remReg[p] <= remReg[p] - 1'b1;
                            end
                        end
                        if (unitDone) begin
                            unitReg <= '0;
                            curReg  <= selIdx;
                        end else begin
                            unitReg <= unitInc;
                        end
                        if (jobLast) begin
                            stateReg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (outVldReg && outEofReg && rdyEff) begin
                        stateReg <= IDLE;
                        doneReg  <= 1'b1;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign out_vld  = outVldReg;
    assign out_sof  = outSofReg;
    assign out_eof  = outEofReg;
    assign out_num  = outNumReg;
    assign out_data = outDataReg;
    assign busy     = (stateReg != IDLE);
    assign done     = doneReg;

endmodule

// File: tb/tb_ics_combine_pack.sv
module tb_ics_combine_pack;
    import ics_pkg::*;

    localparam int NP = 3;
    localparam int RW = 10;
    localparam int OR = 12;
    localparam int LW = 14;
    localparam int NW = ics_num_w(OR);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        q_size;
    logic [NP-1:0]     part_en;
    logic [NP*LW-1:0]  part_rows;
    logic [NP-1:0]     in_vld;
    logic [NP*RW-1:0]  in_data;
    logic [NP-1:0]     in_rdy;
    logic              out_vld;
    logic              out_sof;
    logic              out_eof;
    logic [NW-1:0]     out_num;
    logic [OR*RW-1:0]  out_data;
    logic              out_rdy;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    ics_combine_pack #(
        .NUM_PART (NP),
        .ROW_W    (RW),
        .OUT_ROWS (OR),
        .LEN_W    (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .q_size    (q_size),
        .part_en   (part_en),
        .part_rows (part_rows),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .in_rdy    (in_rdy),
        .out_vld   (out_vld),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_num   (out_num),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [NW-1:0]    num;
        logic             sof;
        logic             eof;
        logic [OR*RW-1:0] data;
    } beat_t;

    int    checks   = 0;
    int    failures = 0;
    beat_t beatQ[$];
    int    ordQ[$];
    int    cnt[NP];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] rowVal(input int p, input int j);
        return RW'((p << 8) | (j & 8'hff));
    endfunction

    // Reference packing: round-robin order of parts, beats of OR rows.
    task automatic build_expect(input int q, input logic [NP-1:0] en,
                                input int r0, input int r1, input int r2,
                                output int total);
        int    rem[NP];
        int    taken[NP];
        int    cur;
        int    unit;
        int    k;
        int    qe;
        int    n;
        logic  first;
        logic  found;
        beat_t b;
        qe     = (q == 0) ? 1 : q;
        rem[0] = en[0] ? r0 : 0;
        rem[1] = en[1] ? r1 : 0;
        rem[2] = en[2] ? r2 : 0;
        total  = rem[0] + rem[1] + rem[2];
        cur    = -1;
        for (int p = 0; p < NP; p++) begin
            taken[p] = 0;
            if (cur < 0 && rem[p] > 0) cur = p;
        end
        b.data = '0;
        b.num  = '0;
        b.sof  = 1'b0;
        b.eof  = 1'b0;
        k      = 0;
        unit   = 0;
        first  = 1'b1;
        for (int left = total; left > 0; left--) begin
            ordQ.push_back(cur);
            b.data[(OR-1-k)*RW +: RW] = rowVal(cur, taken[cur]);
            taken[cur]++;
            rem[cur]--;
            unit++;
            k++;
            if (k == OR || left == 1) begin
                b.num = NW'(k);
                b.sof = first;
                b.eof = (left == 1);
                beatQ.push_back(b);
                first  = 1'b0;
                k      = 0;
                b.data = '0;
            end
            if (unit == qe || rem[cur] == 0) begin
                unit  = 0;
                found = 1'b0;
                for (int i = 1; i <= NP; i++) begin
                    n = (cur + i) % NP;
                    if (!found && rem[n] > 0) begin
                        found = 1'b1;
                        cur   = n;
                    end
                end
            end
        end
    endtask

    // One job: start, feed rows, score beats. stallLen>0 holds out_rdy low
    // from cycle stallAt; rstAfter>0 resets once that many rows are in;
    // dupAt>0 pulses start again (with other config) at that cycle.
    task automatic run_job(input string name, input int q, input logic [NP-1:0] en,
                           input int r0, input int r1, input int r2,
                           input int stallAt, input int stallLen,
                           input int rstAfter, input int dupAt);
        int               total;
        int               doneCnt;
        int               doneCyc;
        int               rowsAcc;
        int               cyc;
        int               expPart;
        logic             fin;
        logic             aborted;
        logic             acc;
        logic             holdVld;
        logic [OR*RW-1:0] holdData;
        logic [NW-1:0]    holdNum;
        logic             holdSof;
        logic             holdEof;
        beat_t            b;

        build_expect(q, en, r0, r1, r2, total);
        $display("job %s: q=%0d en=%b rows=%0d/%0d/%0d total=%0d", name, q, en, r0, r1, r2, total);
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        doneCnt  = 0;
        doneCyc  = -1;
        rowsAcc  = 0;
        cyc      = 0;
        fin      = 1'b0;
        aborted  = 1'b0;
        holdVld  = 1'b0;
        holdData = '0;
        holdNum  = '0;
        holdSof  = 1'b0;
        holdEof  = 1'b0;

        @(negedge clk);
        start     = 1'b1;
        q_size    = 4'(q);
        part_en   = en;
        part_rows = {LW'(r2), LW'(r1), LW'(r0)};
        out_rdy   = 1'b1;

        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            // Config inputs change after start; the job must not notice.
            start     = (cyc == dupAt);
            q_size    = 4'd1;
            part_en   = '1;
            part_rows = {LW'(7), LW'(7), LW'(7)};

            if (cyc == 1) check("busy_after_start", busy, (total > 0));
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end

            if (rstAfter > 0 && rowsAcc == rstAfter) begin
                rst    = 1'b1;
                start  = 1'b0;
                in_vld = '0;
                @(posedge clk);
                @(negedge clk);
                check("rst_out_vld", out_vld, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_in_rdy", in_rdy, '0);
                check("rst_out_data", out_data, '0);
                check("rst_out_num", out_num, '0);
                check("rst_done", done, 1'b0);
                rst = 1'b0;
                beatQ.delete();
                ordQ.delete();
                aborted = 1'b1;
                fin     = 1'b1;
            end else begin
`ifdef ICS_PACK_BP_EN
                if (holdVld) begin
                    check("hold_vld", out_vld, 1'b1);
                    check("hold_data", out_data, holdData);
                    check("hold_num", out_num, holdNum);
                    check("hold_sofeof", {out_sof, out_eof}, {holdSof, holdEof});
                end
                if (stallLen > 0 && cyc >= stallAt + 16 && cyc < stallAt + stallLen)
                    check("stall_in_rdy", in_rdy, '0);
`endif
                for (int p = 0; p < NP; p++) in_data[p*RW +: RW] = rowVal(p, cnt[p]);
                in_vld  = '1;
                out_rdy = !(stallLen > 0 && cyc >= stallAt && cyc < stallAt + stallLen);
                #1;
                check("in_rdy_onehot", ($countones(in_rdy) <= 1), 1'b1);
                for (int p = 0; p < NP; p++) begin
                    if (in_vld[p] && in_rdy[p]) begin
                        expPart = (ordQ.size() > 0) ? ordQ.pop_front() : -1;
                        check("row_part", p, expPart);
                        cnt[p]++;
                        rowsAcc++;
                    end
                end
`ifdef ICS_PACK_BP_EN
                acc = out_vld && out_rdy;
`else
                acc = out_vld;
`endif
                if (acc) begin
                    $display("  beat num=%0d sof=%0b eof=%0b data=%h", out_num, out_sof, out_eof, out_data);
                    if (beatQ.size() == 0) begin
                        check("extra_beat", out_vld, 1'b0);
                    end else begin
                        b = beatQ.pop_front();
                        check("beat_num", out_num, b.num);
                        check("beat_sof", out_sof, b.sof);
                        check("beat_eof", out_eof, b.eof);
                        check("beat_data", out_data, b.data);
                    end
                end
                holdVld  = out_vld && !acc;
                holdData = out_data;
                holdNum  = out_num;
                holdSof  = out_sof;
                holdEof  = out_eof;
                if (doneCnt > 0 && cyc > doneCyc + 3) fin = 1'b1;
            end
        end

        in_vld = '0;
        start  = 1'b0;
        if (!aborted) begin
            check("done_count", doneCnt, 1);
            check("beats_left", beatQ.size(), 0);
            check("rows_left", ordQ.size(), 0);
            check("busy_end", busy, 1'b0);
            if (total == 0) check("empty_done_cycle", doneCyc, 1);
        end
        beatQ.delete();
        ordQ.delete();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        q_size    = '0;
        part_en   = '0;
        part_rows = '0;
        in_vld    = '0;
        in_data   = '0;
        out_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_vld", out_vld, 1'b0);
        check("reset_sofeof", {out_sof, out_eof}, 2'b00);
        check("reset_out_num", out_num, '0);
        check("reset_out_data", out_data, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_in_rdy", in_rdy, '0);
        rst = 1'b0;

        run_job("round_robin",   2, 3'b111,  3, 1, 2,  0,  0, 0, 0);
        run_job("multi_beat",    4, 3'b001, 25, 4, 4,  0,  0, 0, 0);
        run_job("disabled_empty",3, 3'b101,  5, 5, 0,  0,  0, 0, 0);
        run_job("all_empty",     2, 3'b111,  0, 0, 0,  0,  0, 0, 0);
        run_job("backpressure",  4, 3'b001, 25, 0, 0, 10, 20, 0, 0);
        run_job("reset_mid",     2, 3'b111,  6, 6, 6,  0,  0, 7, 0);
        run_job("after_reset",   0, 3'b111,  2, 3, 4,  0,  0, 0, 0);
        run_job("start_busy",    3, 3'b111,  4, 5, 6,  0,  0, 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
